// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ packet requesters, the arbiter and a UART transmitter.
// master = arbiter side, slave = requesters/UART side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [ID_W-1:0]      grant_id;
  logic                 active;
  logic                 pkt_done;

  modport master (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant_id, active, pkt_done
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, active, pkt_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter, one byte per frame, grant held per packet.
// Define UART_ARB_HDR_EN to prefix each packet with header byte {4'hA, grant_id}.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [2:0] S_IDLE     = 3'd0;
`ifdef UART_ARB_HDR_EN
  localparam logic [2:0] S_HDR      = 3'd1;
  localparam logic [2:0] S_HDR_WAIT = 3'd2;
`endif
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;

  logic [2:0]         state;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_grant;
  logic               last_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               pkt_done_q;

  logic               found;
  logic [ID_W-1:0]    next_id;
  logic [ID_W-1:0]    cand;
  logic [7:0]         gnt_byte;
  logic               gnt_valid;
  logic               gnt_last;
  logic               take;
  logic [NUM_REQ-1:0] ready;

  // Round-robin search starting one past the previous packet owner
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        next_id = cand;
      end
    end
  end

  always_comb begin
    gnt_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) gnt_byte = bus.req_data[8*i +: 8];
    end
  end

  assign gnt_valid = bus.req_valid[grant_q];
  assign gnt_last  = bus.req_last[grant_q];
  assign take      = (state == S_LOAD) && gnt_valid && !bus.tx_busy;

  always_comb begin
    ready = '0;
    if (take) ready[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      pkt_done_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_q <= next_id;
`ifdef UART_ARB_HDR_EN
            state   <= S_HDR;
`else
            state   <= S_LOAD;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        S_HDR: begin
          tx_data_q  <= {4'hA, 4'(grant_q)};
          tx_start_q <= 1'b1;
          state      <= S_HDR_WAIT;
        end
        S_HDR_WAIT: begin
          if (bus.tx_done) state <= S_LOAD;
        end
`endif
        S_LOAD: begin
          if (take) begin
            tx_data_q  <= gnt_byte;
            tx_start_q <= 1'b1;
            last_q     <= gnt_last;
            state      <= S_WAIT;
          end
        end
        // Busy is ignored here; only the frame-complete pulse advances
        S_WAIT: begin
          if (bus.tx_done) begin
            if (last_q) begin
              pkt_done_q <= 1'b1;
              last_grant <= grant_q;
              state      <= S_IDLE;
            end else begin
              state      <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.active    = (state != S_IDLE);
  assign bus.pkt_done  = pkt_done_q;
endmodule
